sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the phase increment.
REQ-002 SHALL have parameter DWELL_W, default 16: width of the dwell count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: abort request.
REQ-007 SHALL have ports incr_start and incr_end, input, WIDTH bits each: first and last phase increment.
REQ-008 SHALL have port incr_step, input, WIDTH bits: increment change per dwell period.
REQ-009 SHALL have port dwell, input, DWELL_W bits: en-cycles per increment value; 0 is treated as 1.
REQ-010 SHALL have port en, output, 1 bit: phase-counter enable.
REQ-011 SHALL have port incr, output, WIDTH bits: phase-counter increment.
REQ-012 SHALL have port phase_clr, output, 1 bit: active-high one-cycle clear to the phase counter.
REQ-013 SHALL have ports busy, done and step_pulse, output, 1 bit each: sweep active, sweep-completed pulse, increment-changed pulse.

Function
REQ-014 SHALL implement states IDLE, LOAD, RUN and DONE; all outputs registered.
REQ-015 IDLE: start=1 -> LOAD next cycle; outputs en=0, busy=0, incr holds 0.
REQ-016 LOAD: lasts one cycle.
- Latch incr_start into incr.
- Latch incr_end, incr_step and dwell into internal registers.
- Clear the dwell timer.
- Drive phase_clr=1 and busy=1.
- Go to RUN.
REQ-017 Latency SHALL be: start sampled at edge t -> phase_clr=1 after edge t+1 -> en=1 after edge t+2.
REQ-018 RUN: en=1 and busy=1; the dwell timer counts en-cycles 0..dwell_l-1.
REQ-019 RUN, timer at terminal count and incr==incr_end -> DONE.
REQ-020 RUN, timer at terminal count and incr!=incr_end:
- Load the next value and restart the timer.
- Pulse step_pulse for one cycle, coincident with the new incr.
REQ-021 Direction SHALL be fixed at LOAD: ascending if incr_start<=incr_end, else descending.
REQ-022 Next value SHALL be computed in WIDTH+1 bits as incr±step.
- If the result passes incr_end or overflows/underflows WIDTH, the value is incr_end.
- incr SHALL never wrap.
REQ-023 incr_step=0 SHALL step directly to incr_end at the first terminal count.
REQ-024 DONE: lasts one cycle with done=1, en=0, busy=0; then IDLE; incr returns to 0 in IDLE.
REQ-025 stop=1 in LOAD or RUN -> IDLE at the next edge: en=0, busy=0, no done, no step_pulse.
- stop has priority over terminal count and over start.
REQ-026 start outside IDLE SHALL be ignored; input changes after LOAD SHALL not affect the running sweep.
REQ-027 start and stop both high in IDLE SHALL leave the block in IDLE.

Reset
REQ-028 rst=0 at a clock edge SHALL force:
- state IDLE, timer 0
- incr=0, en=0, phase_clr=0, busy=0, done=0, step_pulse=0
REQ-029 Reset mid-sweep SHALL abort without a done pulse; the next start after rst=1 SHALL begin a fresh sweep.

Structure
REQ-030 Package sweep_pkg SHALL hold the state enum typedef and the default WIDTH/DWELL_W constants.
REQ-031 The dwell timer SHALL be a sub-module dwell_timer.
- Inputs: clear, enable, terminal value.
- Output: terminal-count flag.
REQ-032 en, incr and phase_clr SHALL connect directly to the enable, increment and reset of the existing phase-counter/ROM sine generator.

Verification
REQ-033 Ascending: start=1, end=4, step=1, dwell=3 -> incr 1,2,3,4 for 3 en-cycles each; 3 step_pulses; done after 12 RUN cycles.
REQ-034 Clamp: start=250, end=255, step=4, dwell=2 -> incr 250,254,255; no wrap to low values; done once.
REQ-035 Descending: start=40, end=10, step=15, dwell=1 -> incr 40,25,10 on consecutive cycles, then done.
REQ-036 Abort: stop during the second dwell of REQ-033 -> en=0 and busy=0 next cycle, no done; a new start restarts at incr_start with phase_clr.
REQ-037 Reset mid-RUN: rst=0 for one edge -> all outputs 0 next cycle; start during RUN is ignored.
REQ-038 Degenerate: dwell=0 and start=end=7 -> exactly one RUN cycle with incr=7, then done.

Source files
------------

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default widths for the sweep controller
package sweep_pkg;

  localparam int SWEEP_WIDTH   = 8;
  localparam int SWEEP_DWELL_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - counts enabled cycles from 0 up to a terminal value
module dwell_timer
  import sweep_pkg::*;
#(
  parameter int DWELL_W = SWEEP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] term,
  output logic               tc
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  assign tc = (count_q == term);

  // Wraps at term so a free-running enable still yields evenly spaced flags.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - frequency sweep sequencer driving a phase-accumulator sine generator
module sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH   = SWEEP_WIDTH,
  parameter int DWELL_W = SWEEP_DWELL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   incr_start,
  input  logic [WIDTH-1:0]   incr_end,
  input  logic [WIDTH-1:0]   incr_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic               en,
  output logic [WIDTH-1:0]   incr,
  output logic               phase_clr,
  output logic               busy,
  output logic               done,
  output logic               step_pulse
);

  sweep_state_e       state_q, state_d;
  logic [WIDTH-1:0]   incr_q, incr_d;
  logic [WIDTH-1:0]   end_q, end_d;
  logic [WIDTH-1:0]   step_q, step_d;
  logic [DWELL_W-1:0] term_q, term_d;
  logic               desc_q, desc_d;
  logic               en_q, en_d;
  logic               phase_clr_q, phase_clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               step_pulse_q, step_pulse_d;

  logic               tmr_clear;
  logic               tmr_tc;
  logic               tc_hit;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   next_incr;

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (en_q),
    .term   (term_q),
    .tc     (tmr_tc)
  );

  // Only cycles where the phase counter is actually enabled count toward the dwell.
  assign tc_hit = tmr_tc && en_q;

  // Extra carry/borrow bit catches wrap; anything at or past the end clamps to it.
  always_comb begin
    sum_w     = {1'b0, incr_q} + {1'b0, step_q};
    diff_w    = {1'b0, incr_q} - {1'b0, step_q};
    next_incr = end_q;
    if (step_q != '0) begin
      if (!desc_q && !sum_w[WIDTH] && (sum_w[WIDTH-1:0] < end_q)) begin
        next_incr = sum_w[WIDTH-1:0];
      end else if (desc_q && !diff_w[WIDTH] && (diff_w[WIDTH-1:0] > end_q)) begin
        next_incr = diff_w[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    incr_d       = incr_q;
    end_d        = end_q;
    step_d       = step_q;
    term_d       = term_q;
    desc_d       = desc_q;
    en_d         = 1'b0;
    phase_clr_d  = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    step_pulse_d = 1'b0;
    tmr_clear    = 1'b0;
    case (state_q)
      S_IDLE: begin
        incr_d    = '0;
        tmr_clear = 1'b1;
        if (start && !stop) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        tmr_clear = 1'b1;
        if (stop) begin
          state_d = S_IDLE;
          incr_d  = '0;
        end else begin
          state_d     = S_RUN;
          incr_d      = incr_start;
          end_d       = incr_end;
          step_d      = incr_step;
          term_d      = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          desc_d      = (incr_start > incr_end);
          phase_clr_d = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d   = S_IDLE;
          incr_d    = '0;
          tmr_clear = 1'b1;
        end else if (tc_hit && (incr_q == end_q)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          tmr_clear = 1'b1;
        end else begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          if (tc_hit) begin
            incr_d       = next_incr;
            step_pulse_d = 1'b1;
            tmr_clear    = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        incr_d    = '0;
        tmr_clear = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        incr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      incr_q       <= '0;
      end_q        <= '0;
      step_q       <= '0;
      term_q       <= '0;
      desc_q       <= 1'b0;
      en_q         <= 1'b0;
      phase_clr_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      incr_q       <= incr_d;
      end_q        <= end_d;
      step_q       <= step_d;
      term_q       <= term_d;
      desc_q       <= desc_d;
      en_q         <= en_d;
      phase_clr_q  <= phase_clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign en         = en_q;
  assign incr       = incr_q;
  assign phase_clr  = phase_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - directed self-checking bench for sweep_ctrl
module tb_sweep_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  incr_start;
  logic [7:0]  incr_end;
  logic [7:0]  incr_step;
  logic [15:0] dwell;
  logic        en;
  logic [7:0]  incr;
  logic        phase_clr;
  logic        busy;
  logic        done;
  logic        step_pulse;

  int checks;
  int errors;
  int en_log[$];
  int exp_q[$];
  int n_step;
  int n_done;
  int step_bad;
  int en_gap;
  int done_bad;
  int timed_out;

  sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .incr_start (incr_start),
    .incr_end   (incr_end),
    .incr_step  (incr_step),
    .dwell      (dwell),
    .en         (en),
    .incr       (incr),
    .phase_clr  (phase_clr),
    .busy       (busy),
    .done       (done),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"}, {31'd0, en}, 32'd0);
    check({tag, "_incr"}, {24'd0, incr}, 32'd0);
    check({tag, "_phase_clr"}, {31'd0, phase_clr}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_step_pulse"}, {31'd0, step_pulse}, 32'd0);
  endtask

  // Pulses start for one edge, then checks the LOAD-cycle and phase-clear-cycle outputs.
  task automatic start_sweep(input string tag, input logic [7:0] s, input logic [7:0] e,
                             input logic [7:0] st, input logic [15:0] dw);
    incr_start = s;
    incr_end   = e;
    incr_step  = st;
    dwell      = dw;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_load_en"}, {31'd0, en}, 32'd0);
    @(negedge clk);
    check({tag, "_clr"}, {31'd0, phase_clr}, 32'd1);
    check({tag, "_clr_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_clr_en"}, {31'd0, en}, 32'd0);
    check({tag, "_clr_incr"}, {24'd0, incr}, {24'd0, s});
  endtask

  task automatic run_sweep(input string tag, input int max_cyc);
    int prev;
    int seen_en;
    en_log.delete();
    n_step    = 0;
    n_done    = 0;
    step_bad  = 0;
    en_gap    = 0;
    done_bad  = 0;
    timed_out = 1;
    prev      = -1;
    seen_en   = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (en || busy || step_pulse) done_bad++;
        timed_out = 0;
        break;
      end
      if (en) begin
        en_log.push_back(int'(incr));
        seen_en = 1;
      end else if (seen_en) begin
        en_gap++;
      end
      if (step_pulse) begin
        n_step++;
        if (!en || int'(incr) == prev) step_bad++;
      end
      if (en) prev = int'(incr);
    end
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_done_outputs"}, done_bad, 0);
    check({tag, "_en_gap"}, en_gap, 0);
    check({tag, "_step_coincident"}, step_bad, 0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_incr"}, {24'd0, incr}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, en_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < en_log.size()) check($sformatf("%s_incr[%0d]", tag, i), en_log[i], exp_q[i]);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    incr_start = 8'd0;
    incr_end   = 8'd0;
    incr_step  = 8'd0;
    dwell      = 16'd0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Ascending sweep; inputs scrambled after LOAD must not matter.
    start_sweep("asc", 8'd1, 8'd4, 8'd1, 16'd3);
    incr_start = 8'd99;
    incr_end   = 8'd200;
    incr_step  = 8'd50;
    dwell      = 16'd9;
    run_sweep("asc", 100);
    exp_q = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4};
    check_log("asc");
    check("asc_steps", n_step, 3);
    check("asc_dones", n_done, 1);

    // Clamp at top of range without wrapping.
    start_sweep("clamp", 8'd250, 8'd255, 8'd4, 16'd2);
    run_sweep("clamp", 100);
    exp_q = '{250, 250, 254, 254, 255, 255};
    check_log("clamp");
    check("clamp_steps", n_step, 2);
    check("clamp_dones", n_done, 1);

    // Descending, one cycle per value.
    start_sweep("desc", 8'd40, 8'd10, 8'd15, 16'd1);
    run_sweep("desc", 100);
    exp_q = '{40, 25, 10};
    check_log("desc");
    check("desc_steps", n_step, 2);

    // Degenerate: dwell 0 behaves as 1, start equals end.
    start_sweep("degen", 8'd7, 8'd7, 8'd3, 16'd0);
    run_sweep("degen", 100);
    exp_q = '{7};
    check_log("degen");
    check("degen_steps", n_step, 0);

    // Zero step jumps straight to the end value.
    start_sweep("zstep", 8'd5, 8'd9, 8'd0, 16'd2);
    run_sweep("zstep", 100);
    exp_q = '{5, 5, 9, 9};
    check_log("zstep");

    // Abort during the second dwell period.
    start_sweep("abort", 8'd1, 8'd4, 8'd1, 16'd3);
    repeat (4) @(negedge clk);
    check("abort_second_dwell_incr", {24'd0, incr}, 32'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle_outputs("abort");
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check("abort_no_done", n_done, 0);
    start_sweep("restart", 8'd1, 8'd4, 8'd1, 16'd3);
    run_sweep("restart", 100);
    check("restart_len", en_log.size(), 12);

    // Start during RUN is ignored, then reset mid-sweep.
    start_sweep("rrun", 8'd3, 8'd9, 8'd2, 16'd3);
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rrun_start_ignored_clr", {31'd0, phase_clr}, 32'd0);
    check("rrun_start_ignored_incr", {24'd0, incr}, 32'd3);
    check("rrun_start_ignored_en", {31'd0, en}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_idle_outputs("midreset");
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy || en) n_done++;
    end
    check("midreset_quiet", n_done, 0);
    start_sweep("fresh", 8'd3, 8'd7, 8'd2, 16'd1);
    run_sweep("fresh", 100);
    exp_q = '{3, 5, 7};
    check_log("fresh");

    // start and stop together in IDLE keeps the block idle.
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    check_idle_outputs("start_stop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
